vc_rr_arbiter: RTL and testbench

- Round-robin arbiter with grant locking, placed directly downstream of the request masks that feed priority_encoder in the VC/switch allocation path.
- Takes an N-bit request vector from input VCs or ports and issues one registered grant.
- Holds the grant until the winner asserts release, which it does on the tail flit.
- Uses the fixed-priority encode internally on a pointer-rotated request mask, which gives fair rotation.

---
 rtl/vc_rr_arbiter.sv | 141 ++++++++++++++
 tb/tb_vc_rr_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vc_rr_arbiter.sv
// Round-robin arbiter with grant locking: one registered one-hot grant, held until release_in.
// Latency 1 cycle req->grant; no backpressure. Optional macro VC_RR_ARBITER_HOLD_TIMEOUT_EN forces release after MAX_HOLD cycles.
module vc_rr_arbiter #(
    parameter int NUM_INPUTS = 4,
    parameter int NUM_BITS   = $clog2(NUM_INPUTS),
    parameter int MAX_HOLD   = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_INPUTS-1:0] req,
    input  logic                  release_in,
    output logic                  grant_valid,
    output logic [NUM_INPUTS-1:0] grant,
    output logic [NUM_BITS-1:0]   grant_index
);

    typedef enum logic {
        IDLE    = 1'b0,
        GRANTED = 1'b1
    } state_e;

    if (NUM_INPUTS < 2) begin : g_chk_inputs
        $error("vc_rr_arbiter: NUM_INPUTS must be >= 2");
    end
    if (MAX_HOLD < 1) begin : g_chk_hold
        $error("vc_rr_arbiter: MAX_HOLD must be >= 1");
    end

    state_e                state_q, state_d;
    logic [NUM_BITS-1:0]   ptr_q, ptr_d;
    logic [NUM_INPUTS-1:0] grant_q, grant_d;
    logic [NUM_BITS-1:0]   idx_q, idx_d;
    logic                  vld_q, vld_d;

    logic                  win_found;
    logic [NUM_BITS-1:0]   win_idx;
    logic                  rel_eff;
    logic                  new_grant;
    logic                  timeout;

    // Scan starts at ptr and wraps; equivalent to a priority encode of the rotated request mask.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 0; k < NUM_INPUTS; k++) begin
            if (!win_found && req[(int'(ptr_q) + k) % NUM_INPUTS]) begin
                win_found = 1'b1;
                win_idx   = NUM_BITS'((int'(ptr_q) + k) % NUM_INPUTS);
            end
        end
    end

`ifdef VC_RR_ARBITER_HOLD_TIMEOUT_EN
    localparam int CNT_W = $clog2(MAX_HOLD + 1);

    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;

    assign timeout = (state_q == GRANTED) && (hold_cnt_q == CNT_W'(MAX_HOLD - 1));

    always_comb begin
        hold_cnt_d = '0;
        if (!new_grant && (state_q == GRANTED)) begin
            hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_cnt_q <= '0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    assign rel_eff = release_in | timeout;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        grant_d   = grant_q;
        idx_d     = idx_q;
        vld_d     = vld_q;
        new_grant = 1'b0;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    new_grant = 1'b1;
                end
            end
            GRANTED: begin
                if (rel_eff) begin
                    if (win_found) begin
                        new_grant = 1'b1;
                    end else begin
                        state_d = IDLE;
                        grant_d = '0;
                        idx_d   = '0;
                        vld_d   = 1'b0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                idx_d   = '0;
                vld_d   = 1'b0;
            end
        endcase
        if (new_grant) begin
            state_d = GRANTED;
            grant_d = NUM_INPUTS'(1) << win_idx;
            idx_d   = win_idx;
            vld_d   = 1'b1;
            ptr_d   = NUM_BITS'((int'(win_idx) + 1) % NUM_INPUTS);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
            idx_q   <= '0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            idx_q   <= idx_d;
            vld_q   <= vld_d;
        end
    end

    assign grant_valid = vld_q;
    assign grant       = grant_q;
    assign grant_index = idx_q;

endmodule

// File: tb/tb_vc_rr_arbiter.sv
// Directed bench for vc_rr_arbiter (NUM_INPUTS=4, MAX_HOLD=4); expectations hand-computed.
module tb_vc_rr_arbiter;

    logic       clk;
    logic       reset;
    logic [3:0] req;
    logic       release_in;
    logic       grant_valid;
    logic [3:0] grant;
    logic [1:0] grant_index;

    int n_checks;
    int n_fail;

`ifdef VC_RR_ARBITER_HOLD_TIMEOUT_EN
    localparam int LOCK_HOLD = 2;
`else
    localparam int LOCK_HOLD = 5;
`endif

    vc_rr_arbiter #(
        .NUM_INPUTS(4),
        .MAX_HOLD  (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .release_in (release_in),
        .grant_valid(grant_valid),
        .grant      (grant),
        .grant_index(grant_index)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req = 4'b0000;
        release_in = 1'b0;
        tick();
        tick();
        n_checks++;
        if (grant !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_grant got=%b want=0000", grant);
        end
        n_checks++;
        if (grant_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_valid got=%b want=0", grant_valid);
        end
        reset = 1'b0;
        tick();
        n_checks++;
        if (grant_index !== 2'd0 || grant_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_idle idx=%0d vld=%b want idx=0 vld=0", grant_index, grant_valid);
        end
    endtask

    // Starts from ptr=0: req 0110 -> winner 1, hold, then release hands over to 2.
    task automatic test_lock();
        req = 4'b0110;
        tick();
        n_checks++;
        if (grant !== 4'b0010 || grant_index !== 2'd1 || grant_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL lock_first grant=%b idx=%0d vld=%b want 0010/1/1", grant, grant_index, grant_valid);
        end
        for (int i = 0; i < LOCK_HOLD; i++) begin
            tick();
            n_checks++;
            if (grant !== 4'b0010) begin
                n_fail++;
                $display("FAIL lock_hold[%0d] grant=%b want 0010", i, grant);
            end
        end
        release_in = 1'b1;
        tick();
        release_in = 1'b0;
        n_checks++;
        if (grant !== 4'b0100 || grant_index !== 2'd2 || grant_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL lock_handover grant=%b idx=%0d vld=%b want 0100/2/1", grant, grant_index, grant_valid);
        end
    endtask

    // Locked on 2 with ptr=3: the holder alone requesting wins again.
    task automatic test_sole_rewin();
        req = 4'b0100;
        release_in = 1'b1;
        tick();
        release_in = 1'b0;
        n_checks++;
        if (grant !== 4'b0100 || grant_index !== 2'd2) begin
            n_fail++;
            $display("FAIL sole_rewin grant=%b idx=%0d want 0100/2", grant, grant_index);
        end
    endtask

    task automatic test_drop();
        req = 4'b0000;
        tick();
        n_checks++;
        if (grant !== 4'b0100 || grant_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL drop_hold grant=%b vld=%b want 0100/1", grant, grant_valid);
        end
        release_in = 1'b1;
        tick();
        n_checks++;
        if (grant !== 4'b0000 || grant_valid !== 1'b0 || grant_index !== 2'd0) begin
            n_fail++;
            $display("FAIL drop_idle grant=%b idx=%0d vld=%b want 0000/0/0", grant, grant_index, grant_valid);
        end
        tick();
        release_in = 1'b0;
        n_checks++;
        if (grant_valid !== 1'b0 || grant !== 4'b0000) begin
            n_fail++;
            $display("FAIL idle_release_ignored grant=%b vld=%b want 0000/0", grant, grant_valid);
        end
        // ptr is still 3 here, so 1010 must pick 3.
        req = 4'b1010;
        tick();
        req = 4'b0000;
        n_checks++;
        if (grant !== 4'b1000 || grant_index !== 2'd3) begin
            n_fail++;
            $display("FAIL ptr_kept grant=%b idx=%0d want 1000/3", grant, grant_index);
        end
    endtask

    task automatic test_fairness();
        logic [3:0] exp_seq [5];
        exp_seq[0] = 4'b0001;
        exp_seq[1] = 4'b0010;
        exp_seq[2] = 4'b0100;
        exp_seq[3] = 4'b1000;
        exp_seq[4] = 4'b0001;
        apply_reset();
        req = 4'b1111;
        release_in = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if (grant !== exp_seq[i] || grant_index !== 2'(i % 4) || grant_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL fair[%0d] grant=%b idx=%0d want %b/%0d", i, grant, grant_index, exp_seq[i], i % 4);
            end
        end
        req = 4'b0000;
        tick();
        release_in = 1'b0;
        n_checks++;
        if (grant_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL fair_idle vld=%b want 0", grant_valid);
        end
    endtask

    // Lock on 2 (ptr->3), async reset between edges, then 1010 must pick 1 (ptr back at 0).
    task automatic test_async_reset();
        req = 4'b0100;
        tick();
        req = 4'b0000;
        n_checks++;
        if (grant !== 4'b0100) begin
            n_fail++;
            $display("FAIL ar_setup grant=%b want 0100", grant);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        n_checks++;
        if (grant !== 4'b0000 || grant_valid !== 1'b0 || grant_index !== 2'd0) begin
            n_fail++;
            $display("FAIL ar_immediate grant=%b idx=%0d vld=%b want 0000/0/0", grant, grant_index, grant_valid);
        end
        #2;
        reset = 1'b0;
        req = 4'b1010;
        tick();
        n_checks++;
        if (grant !== 4'b0010 || grant_index !== 2'd1) begin
            n_fail++;
            $display("FAIL ar_ptr0 grant=%b idx=%0d want 0010/1", grant, grant_index);
        end
        apply_reset();
        req = 4'b1000;
        tick();
        req = 4'b0000;
        n_checks++;
        if (grant !== 4'b1000 || grant_index !== 2'd3 || grant_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL ar_req3 grant=%b idx=%0d want 1000/3", grant, grant_index);
        end
    endtask

    task automatic test_hold_timeout();
        apply_reset();
        req = 4'b0011;
        release_in = 1'b0;
        tick();
        n_checks++;
        if (grant !== 4'b0001) begin
            n_fail++;
            $display("FAIL hold_first grant=%b want 0001", grant);
        end
`ifdef VC_RR_ARBITER_HOLD_TIMEOUT_EN
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (grant !== 4'b0001) begin
                n_fail++;
                $display("FAIL hold_cycle[%0d] grant=%b want 0001", i, grant);
            end
        end
        tick();
        n_checks++;
        if (grant !== 4'b0010 || grant_index !== 2'd1) begin
            n_fail++;
            $display("FAIL hold_timeout grant=%b idx=%0d want 0010/1", grant, grant_index);
        end
`else
        for (int i = 0; i < 22; i++) begin
            tick();
            n_checks++;
            if (grant !== 4'b0001 || grant_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL hold_forever[%0d] grant=%b want 0001", i, grant);
            end
        end
`endif
        req = 4'b0000;
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        reset = 1'b1;
        req = 4'b0000;
        release_in = 1'b0;
        test_reset();
        test_lock();
        test_sole_rewin();
        test_drop();
        test_fairness();
        test_async_reset();
        test_hold_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
